// File: rtl/smpl_pkg.sv
// Purpose: shared types and constants for the sample trigger front end.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package smpl_pkg;

    typedef enum logic [1:0] {
        Idle,
        Arm,
        Wait,
        Run
    } trig_state_t;

    typedef enum logic [1:0] {
        TrigAuto,
        TrigNormal,
        TrigFree,
        TrigRsvd
    } trig_mode_t;

    // Trigger configuration, captured once per frame when the consumer asks for samples
    typedef struct packed {
        logic [8:0] level;
        logic       slope;
        trig_mode_t mode;
    } trig_cfg_t;

    localparam logic [9:0] SMPL_CLIP = 10'h200;
    localparam logic [9:0] SMPL_MAX  = 10'h1FF;

    // Below-range samples compare as code 0 in the trigger logic
    function automatic logic [8:0] trig_val(input logic [9:0] s);
        return s[9] ? 9'd0 : s[8:0];
    endfunction

endpackage

// File: rtl/smpl_conv.sv
// Purpose: decimate raw ADC words, remove offset, apply gain shift, clamp to 10-bit display code.
// Latency: decimation hit in cycle t -> cv_vld/cv_dat valid in cycle t+2.
// Backpressure: none; hits are spaced >= 2 cycles apart by the decimation floor of 1.
module smpl_conv
    import smpl_pkg::*;
#(
    parameter int AN = 10
) (
    input  logic          clkSmpl,
    input  logic          n_reset,
    input  logic          adc_valid,
    input  logic [AN-1:0] adc_data,
    input  logic [AN-1:0] adc_offset,
    input  logic [1:0]    gain_shift,
    input  logic [7:0]    decim,
    output logic          cv_vld,
    output logic [9:0]    cv_dat
);

    localparam logic signed [AN:0] VMAX = (AN+1)'(511);

    logic [7:0]         dec_cnt;
    logic [7:0]         dec_lim;
    logic               hit;
    logic signed [AN:0] d_q;
    logic [1:0]         sh_q;
    logic               v1_q;
    logic signed [AN:0] v;
    logic [9:0]         s_nxt;

    // Decimation hit: a decim of 0 behaves as 1 so every hit is at least two words apart;
    // >= lets the counter recover if decim is lowered below the current count
    always_comb begin
        dec_lim = (decim == 8'd0) ? 8'd1 : decim;
        hit     = adc_valid && (dec_cnt >= dec_lim);
    end

    // Decimation counter advances once per valid ADC word
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            dec_cnt <= 8'd0;
        end else if (adc_valid) begin
            dec_cnt <= hit ? 8'd0 : dec_cnt + 8'd1;
        end
    end

    // Stage 1: signed offset removal on the kept word
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            d_q  <= '0;
            sh_q <= 2'd0;
            v1_q <= 1'b0;
        end else begin
            d_q  <= $signed({1'b0, adc_data}) - $signed({1'b0, adc_offset});
            sh_q <= gain_shift;
            v1_q <= hit;
        end
    end

    // Arithmetic shift then clamp into the display format
    always_comb begin
        v = d_q >>> sh_q;
        if (v[AN]) begin
            s_nxt = SMPL_CLIP;
        end else if (v > VMAX) begin
            s_nxt = SMPL_MAX;
        end else begin
            s_nxt = {1'b0, v[8:0]};
        end
    end

    // Stage 2: registered converted sample
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            cv_vld <= 1'b0;
            cv_dat <= SMPL_CLIP;
        end else begin
            cv_vld <= v1_q;
            cv_dat <= s_nxt;
        end
    end

endmodule

// File: rtl/smpl_trigger.sv
// Purpose: edge/auto/free-run trigger over converted samples; streams post-trigger samples.
// Latency: converted sample in cycle t -> smpl_avail pulse / smpl valid in cycle t+1.
// Backpressure: level-based; smpl_req low returns to Idle next cycle and drops any pending sample.
module smpl_trigger
    import smpl_pkg::*;
#(
    parameter int AN   = 10,
    parameter int HYST = 4,
    parameter int AUTO = 4096
) (
    input  logic          clkSmpl,
    input  logic          n_reset,
    input  logic          adc_valid,
    input  logic [AN-1:0] adc_data,
    input  logic [AN-1:0] adc_offset,
    input  logic [1:0]    gain_shift,
    input  logic [7:0]    decim,
    input  logic [8:0]    trig_level,
    input  logic          trig_slope,
    input  logic [1:0]    trig_mode,
    input  logic          smpl_req,
    output logic          smpl_avail,
    output logic [9:0]    smpl,
    output logic          trig_auto
);

    localparam int            TW      = $clog2(AUTO) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(AUTO - 1);

    trig_state_t   state;
    trig_state_t   state_nxt;
    trig_cfg_t     cfg_q;
    logic          req_d;
    logic [TW-1:0] to_cnt;

    logic          cv_vld;
    logic [9:0]    cv_dat;
    logic [8:0]    sv;
    logic [9:0]    lvl_ext;
    logic [9:0]    hi_sum;
    logic [8:0]    arm_lo;
    logic [8:0]    arm_hi;
    logic          arm_ok;
    logic          edge_ok;
    logic          is_free;
    logic          is_auto;
    logic          timeout;

    logic          emit;
    logic          auto_set;
    logic          auto_clr;
    logic          to_clr;
    logic          to_inc;

    smpl_conv #(
        .AN (AN)
    ) u_conv (
        .clkSmpl    (clkSmpl),
        .n_reset    (n_reset),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .adc_offset (adc_offset),
        .gain_shift (gain_shift),
        .decim      (decim),
        .cv_vld     (cv_vld),
        .cv_dat     (cv_dat)
    );

    // Hysteresis thresholds (saturating) and trigger compares against the latched config
    always_comb begin
        sv      = trig_val(cv_dat);
        lvl_ext = {1'b0, cfg_q.level};
        hi_sum  = lvl_ext + 10'(HYST);
        arm_lo  = (lvl_ext >= 10'(HYST)) ? 9'(lvl_ext - 10'(HYST)) : 9'd0;
        arm_hi  = (hi_sum > 10'd511) ? 9'd511 : hi_sum[8:0];
        arm_ok  = cfg_q.slope ? (sv >= arm_hi) : (sv <= arm_lo);
        edge_ok = cfg_q.slope ? (sv <= cfg_q.level) : (sv >= cfg_q.level);
        is_free = (cfg_q.mode == TrigFree) || (cfg_q.mode == TrigRsvd);
        is_auto = (cfg_q.mode == TrigAuto);
        timeout = is_auto && (to_cnt == TO_LAST);
    end

    // State register plus request edge detector
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            state <= Idle;
            req_d <= 1'b0;
        end else begin
            state <= state_nxt;
            req_d <= smpl_req;
        end
    end

    // Next-state: request low always wins and returns to Idle
    always_comb begin
        state_nxt = state;
        if (!smpl_req) begin
            state_nxt = Idle;
        end else begin
            case (state)
                Idle: if (!req_d) state_nxt = Arm;
                Arm: begin
                    if (is_free) begin
                        state_nxt = Run;
                    end else if (cv_vld) begin
                        if (timeout)     state_nxt = Run;
                        else if (arm_ok) state_nxt = Wait;
                    end
                end
                Wait: if (cv_vld && (edge_ok || timeout)) state_nxt = Run;
                Run:  state_nxt = Run;
                default: state_nxt = Idle;
            endcase
        end
    end

    // Output decode: which sample to emit, trig_auto updates, timeout counter control
    always_comb begin
        emit     = 1'b0;
        auto_set = 1'b0;
        auto_clr = 1'b0;
        to_clr   = 1'b0;
        to_inc   = 1'b0;
        case (state)
            Idle: to_clr = 1'b1;
            Arm: begin
                if (smpl_req) begin
                    if (is_free) begin
                        auto_set = 1'b1;
                    end else if (cv_vld) begin
                        if (timeout) begin
                            emit     = 1'b1;
                            auto_set = 1'b1;
                        end else begin
                            to_inc = is_auto;
                        end
                    end
                end
            end
            Wait: begin
                if (smpl_req && cv_vld) begin
                    if (edge_ok) begin
                        emit     = 1'b1;
                        auto_clr = 1'b1;
                    end else if (timeout) begin
                        emit     = 1'b1;
                        auto_set = 1'b1;
                    end else begin
                        to_inc = is_auto;
                    end
                end
            end
            Run: emit = smpl_req && cv_vld;
            default: to_clr = 1'b1;
        endcase
    end

    // Capture trigger config only on the request rise that starts a frame
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            cfg_q <= '0;
        end else if (state == Idle && smpl_req && !req_d) begin
            cfg_q <= '{level: trig_level, slope: trig_slope, mode: trig_mode_t'(trig_mode)};
        end
    end

    // Auto-mode timeout counter, counts converted samples while waiting for an edge
    always_ff @(posedge clkSmpl) begin
        if (!n_reset || to_clr) begin
            to_cnt <= '0;
        end else if (to_inc) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Output registers: avail is a single-cycle pulse, smpl holds between pulses
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            smpl_avail <= 1'b0;
            smpl       <= SMPL_CLIP;
            trig_auto  <= 1'b0;
        end else begin
            smpl_avail <= emit;
            if (emit) smpl <= cv_dat;
            if (auto_set)      trig_auto <= 1'b1;
            else if (auto_clr) trig_auto <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smpl_trigger.sv
// Purpose: directed self-checking bench for smpl_trigger (conversion, decimation, trigger modes).
// Latency: n/a.
// Backpressure: n/a.
module tb_smpl_trigger;

    logic       clkSmpl = 1'b0;
    logic       n_reset;
    logic       adc_valid;
    logic [9:0] adc_data;
    logic [9:0] adc_offset;
    logic [1:0] gain_shift;
    logic [7:0] decim;
    logic [8:0] trig_level;
    logic       trig_slope;
    logic [1:0] trig_mode;
    logic       smpl_req;
    logic       smpl_avail;
    logic [9:0] smpl;
    logic       trig_auto;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    int avail_cnt = 0;
    int last_cyc = 0;
    int last_gap = 0;
    logic [9:0] vals [$];

    int n0;

    always #5 clkSmpl = ~clkSmpl;

    smpl_trigger #(
        .AN   (10),
        .HYST (4),
        .AUTO (16)
    ) dut (
        .clkSmpl    (clkSmpl),
        .n_reset    (n_reset),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .adc_offset (adc_offset),
        .gain_shift (gain_shift),
        .decim      (decim),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .trig_mode  (trig_mode),
        .smpl_req   (smpl_req),
        .smpl_avail (smpl_avail),
        .smpl       (smpl),
        .trig_auto  (trig_auto)
    );

    // Record every avail pulse on the falling edge, away from the active edge
    always @(negedge clkSmpl) begin
        cyc++;
        if (smpl_avail) begin
            avail_cnt++;
            last_gap = cyc - last_cyc;
            last_cyc = cyc;
            vals.push_back(smpl);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkSmpl);
            #1;
        end
    endtask

    // Sample recorded at index idx, or an impossible code if it never arrived
    function automatic logic [9:0] get_val(input int idx);
        if (idx < vals.size()) return vals[idx];
        return 10'h3FF;
    endfunction

    initial begin
        n_reset    = 1'b0;
        adc_valid  = 1'b1;
        adc_data   = 10'd0;
        adc_offset = 10'd0;
        gain_shift = 2'd0;
        decim      = 8'd1;
        trig_level = 9'd0;
        trig_slope = 1'b0;
        trig_mode  = 2'd0;
        smpl_req   = 1'b0;
        tick(3);
        chk_eq("reset_smpl",  32'(smpl), 32'h200);
        chk_eq("reset_avail", 32'(smpl_avail), 32'h0);
        chk_eq("reset_auto",  32'(trig_auto), 32'h0);
        n_reset = 1'b1;
        tick(1);

        // Conversion, observed through free-run streaming
        trig_mode  = 2'd2;
        smpl_req   = 1'b1;
        adc_data   = 10'd612;
        adc_offset = 10'd100;
        gain_shift = 2'd1;
        tick(12);
        chk_eq("conv_612", 32'(smpl), 32'd256);
        chk_eq("free_auto", 32'(trig_auto), 32'h1);
        adc_data = 10'd50;
        tick(8);
        chk_eq("conv_below", 32'(smpl), 32'h200);
        adc_data   = 10'd1023;
        adc_offset = 10'd0;
        gain_shift = 2'd0;
        tick(8);
        chk_eq("conv_above", 32'(smpl), 32'h1FF);

        // Decimation spacing of avail pulses
        decim = 8'd0;
        tick(12);
        chk_eq("decim0_gap", 32'(last_gap), 32'd2);
        decim = 8'd3;
        tick(24);
        chk_eq("decim3_gap", 32'(last_gap), 32'd4);
        decim = 8'd1;
        tick(4);

        // Request drop mid-Run
        smpl_req = 1'b0;
        tick(1);
        chk_eq("drop_avail", 32'(smpl_avail), 32'h0);
        n0 = avail_cnt;
        tick(20);
        chk_eq("drop_quiet", 32'(avail_cnt - n0), 32'd0);

        // Rising edge, normal mode, ramp one code per decimated sample
        trig_mode  = 2'd1;
        trig_slope = 1'b0;
        trig_level = 9'd200;
        adc_data   = 10'd0;
        tick(4);
        smpl_req = 1'b1;
        tick(6);
        n0 = avail_cnt;
        for (int v = 1; v <= 260; v++) begin
            adc_data = 10'(v);
            tick(2);
        end
        chk_eq("ramp_first",  32'(get_val(n0)), 32'd200);
        chk_eq("ramp_second", 32'(get_val(n0 + 1)), 32'd201);
        chk_eq("ramp_tenth",  32'(get_val(n0 + 10)), 32'd210);
        chk_eq("ramp_auto",   32'(trig_auto), 32'h0);

        // Auto timeout: level never reached, forced trigger on the 16th sample
        smpl_req   = 1'b0;
        trig_mode  = 2'd0;
        trig_level = 9'd300;
        adc_data   = 10'd100;
        tick(4);
        n0 = avail_cnt;
        smpl_req = 1'b1;
        tick(31);
        chk_eq("auto_early", 32'(avail_cnt - n0), 32'd0);
        tick(2);
        chk_eq("auto_fire", 32'(avail_cnt - n0), 32'd1);
        chk_eq("auto_val",  32'(get_val(n0)), 32'd100);
        chk_eq("auto_flag", 32'(trig_auto), 32'h1);

        // Same input in normal mode never triggers
        smpl_req  = 1'b0;
        trig_mode = 2'd1;
        tick(2);
        n0 = avail_cnt;
        smpl_req = 1'b1;
        tick(1000);
        chk_eq("normal_quiet", 32'(avail_cnt - n0), 32'd0);

        // Falling edge: noise around the level never arms, square wave triggers once
        smpl_req   = 1'b0;
        trig_slope = 1'b1;
        trig_level = 9'd200;
        tick(2);
        smpl_req = 1'b1;
        n0 = avail_cnt;
        for (int i = 0; i < 40; i++) begin
            adc_data = (i % 2 == 1) ? 10'd201 : 10'd199;
            tick(2);
        end
        chk_eq("fall_noise", 32'(avail_cnt - n0), 32'd0);
        adc_data = 10'd300;
        tick(8);
        adc_data = 10'd100;
        tick(10);
        chk_eq("fall_first",  32'(get_val(n0)), 32'd100);
        chk_eq("fall_second", 32'(get_val(n0 + 1)), 32'd100);
        chk_eq("fall_auto",   32'(trig_auto), 32'h0);

        // Reset mid-Wait, then re-arm with a new (free-run) config
        smpl_req   = 1'b0;
        trig_slope = 1'b0;
        adc_data   = 10'd0;
        tick(2);
        smpl_req = 1'b1;
        tick(8);
        n_reset   = 1'b0;
        trig_mode = 2'd2;
        adc_data  = 10'd123;
        tick(1);
        chk_eq("rst_smpl",  32'(smpl), 32'h200);
        chk_eq("rst_avail", 32'(smpl_avail), 32'h0);
        chk_eq("rst_auto",  32'(trig_auto), 32'h0);
        n_reset  = 1'b1;
        smpl_req = 1'b0;
        tick(2);
        n0 = avail_cnt;
        smpl_req = 1'b1;
        tick(10);
        chk_eq("rearm_val",  32'(get_val(n0)), 32'd123);
        chk_eq("rearm_auto", 32'(trig_auto), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
